// File: rtl/fft_pkg.sv
// Shared types for the radix-2 DIT FFT butterfly scheduler:
// FSM states, write-back delay bundle, per-butterfly address helper.
package fft_pkg;

  localparam int MAX_LOG2 = 12;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fsm_t;

  typedef struct packed {
    logic        valid;
    logic [11:0] addr_a;
    logic [11:0] addr_b;
  } dly_t;

  typedef struct packed {
    logic [11:0] addr_a;
    logic [11:0] addr_b;
    logic [10:0] tw;
  } bfly_addr_t;

  // Butterfly k of stage s in an lg-bit transform.
  // Spreads k around the span bit h, then scales
  // the in-group offset to the twiddle index.
  function automatic bfly_addr_t fft_bfly_addr(
    input logic [3:0]  s,
    input logic [10:0] k,
    input int          lg
  );
    bfly_addr_t  r;
    logic [11:0] kk;
    logic [11:0] h;
    logic [11:0] lo;
    int          sh;
    kk       = {1'b0, k};
    h        = 12'd1 << s;
    lo       = kk & (h - 12'd1);
    r.addr_a = ((kk >> s) << (s + 4'd1)) | lo;
    r.addr_b = r.addr_a + h;
    sh       = lg - 1 - int'(s);
    r.tw     = 11'(lo << sh);
    return r;
  endfunction

endpackage

// File: rtl/fft_sched_delay.sv
// Fixed-depth shift register with synchronous clear.
// Ports: clk, clr (sync clear), din -> dout after DEPTH cycles.
module fft_sched_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fft_bfly_scheduler.sv
// In-place radix-2 DIT FFT scheduler: issues read/twiddle addresses
// per butterfly and replays them delayed as write-back addresses.
// Ports: clk, rst (sync, high), start, stall -> busy, done, stage,
// rd_en, rd_addr_a/b, tw_addr, wr_en, wr_addr_a/b.
// Option FFT_SCHED_STATS_EN adds the stall_cycles counter output.
module fft_bfly_scheduler
  import fft_pkg::*;
#(
  parameter int LOG2_N   = 4,
  parameter int RD_LAT   = 1,
  parameter int BFLY_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stall,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(LOG2_N)-1:0] stage,
  output logic                      rd_en,
  output logic [LOG2_N-1:0]         rd_addr_a,
  output logic [LOG2_N-1:0]         rd_addr_b,
  output logic [LOG2_N-2:0]         tw_addr,
  output logic                      wr_en,
  output logic [LOG2_N-1:0]         wr_addr_a,
  output logic [LOG2_N-1:0]         wr_addr_b
`ifdef FFT_SCHED_STATS_EN
  ,
  output logic [15:0]               stall_cycles
`endif
);

  localparam int SW = $clog2(LOG2_N);
  localparam int KW = LOG2_N - 1;
  localparam int DL = RD_LAT + BFLY_LAT;
  localparam int CW = $clog2(DL + 1);

  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2_N - 1);
  localparam logic [CW-1:0] C_LOAD = CW'(DL);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  fsm_t          state;
  logic [SW-1:0] s;
  logic [KW-1:0] k;
  logic [CW-1:0] cnt;

  bfly_addr_t ba;
  dly_t       din;
  dly_t       dout;
  logic       unused_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s     <= '0;
      k     <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            s     <= '0;
            k     <= '0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (k == K_LAST) begin
              state <= DRAIN;
              cnt   <= C_LOAD;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        // Hold off the next stage until the last
        // write of this one has left the pipe.
        DRAIN: begin
          if (cnt == C_ONE) begin
            k <= '0;
            if (s == S_LAST) begin
              state <= DONE;
            end else begin
              s     <= s + SW'(1);
              state <= RUN;
            end
          end else begin
            cnt <= cnt - C_ONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ba = fft_bfly_addr(4'(s), 11'(k), LOG2_N);

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign stage = s;
  assign rd_en = (state == RUN) && !stall;

  // Addresses read as zero whenever no read is issued.
  assign rd_addr_a = rd_en ? ba.addr_a[LOG2_N-1:0] : '0;
  assign rd_addr_b = rd_en ? ba.addr_b[LOG2_N-1:0] : '0;
  assign tw_addr   = rd_en ? ba.tw[LOG2_N-2:0] : '0;

  assign din = '{
    valid:  rd_en,
    addr_a: 12'(rd_addr_a),
    addr_b: 12'(rd_addr_b)
  };

  fft_sched_delay #(
    .DEPTH(DL),
    .WIDTH($bits(dly_t))
  ) u_wb (
    .clk  (clk),
    .clr  (rst),
    .din  (din),
    .dout (dout)
  );

  assign wr_en     = dout.valid;
  assign wr_addr_a = dout.addr_a[LOG2_N-1:0];
  assign wr_addr_b = dout.addr_b[LOG2_N-1:0];

  assign unused_bits = ^{ba, dout};

`ifdef FFT_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state == IDLE && start) begin
      stall_cycles <= '0;
    end else if (state == RUN && stall &&
                 stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
